// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller: FSM states, core request/response structs.
// No logic; lane helper is purely combinational.
package dmem_ctrl_pkg;

    localparam int dmem_byte_lanes_gp = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [31:0] s;
        s = w >> {lane, 3'b000};
        return s[7:0];
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port byte-lane RAM, 2^addr_width_p x 32, per-lane write enables.
// Latency: read data registered, valid the cycle after en; holds until the next read.
// Backpressure: none, accesses only when en is high.
module dmem_bank
    import dmem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [3:0]              we,
    input  logic [addr_width_p-1:0] addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata
);

    logic [31:0] mem [2**addr_width_p];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < dmem_byte_lanes_gp; i++) begin
                if (we[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one word/byte load or store in flight on a local RAM (macro DMEM_MISALIGN_TRAP_EN).
// Latency: response valid latency_p cycles after acceptance; RAM touched once, on BUSY->RESP.
// Backpressure: yumi only in IDLE; response held in RESP until the core's yumi.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     req_i,
    input  logic [31:0] addr_i,
    output mem_out_s    resp_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam logic [2:0] cnt_init_lp = 3'(latency_p - 1);

    dmem_state_e             state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    accept;
    logic [addr_width_p-1:0] idx_q;
    logic [1:0]              lane_q;
    logic [31:0]             wdata_q;
    logic                    wen_q, bnw_q;
    logic                    mis_q;

    logic                    bank_en;
    logic [3:0]              bank_we;
    logic [31:0]             bank_wdata, bank_rdata;

    logic unused_addr;
    assign unused_addr = ^addr_i[31:addr_width_p+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i.valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = cnt_init_lp;
                end
            end
            BUSY: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (req_i.yumi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            bnw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= addr_i[addr_width_p+1:2];
                lane_q  <= addr_i[1:0];
                wdata_q <= req_i.write_data;
                wen_q   <= req_i.wen;
                bnw_q   <= req_i.byte_not_word;
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_d, err_q;
    assign mis_d = !req_i.byte_not_word && (addr_i[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else if (accept) begin
            mis_q <= mis_d;
            if (mis_d) begin
                err_q <= 1'b1;
            end
        end
    end
    assign err_o = err_q;
`else
    // Word accesses ignore addr[1:0]: the bank index already aligns them down.
    assign mis_q = 1'b0;
    assign err_o = 1'b0;
`endif

    // The bank's registered read lands exactly as the FSM enters RESP.
    assign bank_en    = (state_q == BUSY) && (cnt_q == 3'd0);
    assign bank_we    = (wen_q && !mis_q) ? (bnw_q ? (4'b0001 << lane_q) : 4'b1111) : 4'b0000;
    assign bank_wdata = bnw_q ? {4{wdata_q[7:0]}} : wdata_q;

    dmem_bank #(
        .addr_width_p(addr_width_p)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .we    (bank_we),
        .addr  (idx_q),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    always_comb begin
        resp_o       = '0;
        resp_o.yumi  = accept;
        resp_o.valid = (state_q == RESP);
        if ((state_q == RESP) && !wen_q && !mis_q) begin
            resp_o.read_data = bnw_q ? {24'd0, lane_byte(bank_rdata, lane_q)} : bank_rdata;
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed transactions, a behavioural memory model checked every cycle,
// and literal expectations on the returned data.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    mem_in_s     req;
    logic [31:0] addr;
    mem_out_s    resp;
    logic        err, busy;

    always #5 clk = ~clk;

    dmem_ctrl #(.addr_width_p(AW), .latency_p(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req),
        .addr_i (addr),
        .resp_o (resp),
        .err_o  (err),
        .busy_o (busy)
    );

    // Behavioural model: a transaction is in flight from acceptance until the core's yumi;
    // its result is computed on the memory array once LAT cycles have elapsed.
    logic [31:0] mm [2**AW];
    logic        in_flight = 1'b0;
    int          age = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_data = '0;
    logic [31:0] q_addr = '0, q_wd = '0;
    logic        q_wen = 1'b0, q_bnw = 1'b0, q_mis = 1'b0;

    always @(posedge clk or negedge reset) begin : model
        int          idx;
        int          ln;
        logic        mis;
        if (!reset) begin
            in_flight <= 1'b0;
            age       <= 0;
            m_err     <= 1'b0;
        end else if (!in_flight) begin
            if (req.valid) begin
`ifdef DMEM_MISALIGN_TRAP_EN
                mis = !req.byte_not_word && (addr[1:0] != 2'b00);
`else
                mis = 1'b0;
`endif
                in_flight <= 1'b1;
                age       <= 0;
                q_addr    <= addr;
                q_wd      <= req.write_data;
                q_wen     <= req.wen;
                q_bnw     <= req.byte_not_word;
                q_mis     <= mis;
                if (mis) m_err <= 1'b1;
            end
        end else if (age < LAT) begin
            age <= age + 1;
            if (age + 1 == LAT) begin
                idx = int'(q_addr[AW+1:2]);
                ln  = int'(q_addr[1:0]);
                if (q_wen) begin
                    m_data <= 32'd0;
                    if (!q_mis) begin
                        if (q_bnw) mm[idx][ln*8 +: 8] <= q_wd[7:0];
                        else       mm[idx]            <= q_wd;
                    end
                end else if (q_mis) begin
                    m_data <= 32'd0;
                end else if (q_bnw) begin
                    m_data <= (mm[idx] >> (ln*8)) & 32'h0000_00ff;
                end else begin
                    m_data <= mm[idx];
                end
            end
        end else if (req.yumi) begin
            in_flight <= 1'b0;
        end
    end

    // Literal expectations posted by the stimulus, consumed by the compare process.
    string       lit_name [128];
    logic [31:0] lit_act  [128];
    logic [31:0] lit_exp  [128];
    int          lit_n = 0;
    int          lit_done = 0;

    int checks = 0;
    int passes = 0;

    task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
        lit_name[lit_n] = n;
        lit_act[lit_n]  = a;
        lit_exp[lit_n]  = e;
        lit_n           = lit_n + 1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks = checks + 1;
        if (a === e) passes = passes + 1;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", n, a, e, $time);
    endtask

    always @(negedge clk) begin : compare
        logic exp_valid;
        exp_valid = in_flight && (age == LAT);
        chk("resp_yumi", {31'd0, resp.yumi}, {31'd0, !in_flight && req.valid});
        chk("resp_valid", {31'd0, resp.valid}, {31'd0, exp_valid});
        chk("busy", {31'd0, busy}, {31'd0, in_flight});
        chk("err", {31'd0, err}, {31'd0, m_err});
        if (exp_valid) chk("read_data", resp.read_data, m_data);
        while (lit_done < lit_n) begin
            chk(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
            lit_done = lit_done + 1;
        end
    end

    task automatic xact(input logic w, input logic b, input logic [31:0] a, input logic [31:0] wd,
                        input int hold, input logic keep, input logic [31:0] next_a,
                        output logic [31:0] rd, output int lat, output int yumis);
        int n;
        req.valid = 1'b1;
        req.wen = w;
        req.byte_not_word = b;
        req.write_data = wd;
        addr = a;
        n = 0;
        #1;
        while (!resp.yumi && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!resp.yumi) post("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req.valid = keep;
        if (keep) begin
            addr = next_a;
            req.wen = 1'b0;
            req.byte_not_word = 1'b0;
        end
        lat = 0;
        while (!resp.valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp.valid) post("resp_timeout", 32'd0, 32'd1);
        yumis = 0;
        for (int i = 0; i < hold; i++) begin
            if (resp.yumi) yumis++;
            @(posedge clk); #1;
        end
        rd = resp.read_data;
        req.yumi = 1'b1;
        @(posedge clk); #1;
        req.yumi = 1'b0;
    endtask

    initial begin : global_timeout
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] rd;
        int lat, ys;
        req = '0;
        addr = '0;
        repeat (2) @(posedge clk);
        #1;
        post("reset_read_data", resp.read_data, 32'd0);
        post("reset_valid", {31'd0, resp.valid}, 32'd0);
        post("reset_busy", {31'd0, busy}, 32'd0);
        post("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // word store then load, and an aliased load through the upper address bits
        xact(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0, 0, rd, lat, ys);
        post("store_rd_zero", rd, 32'd0);
        xact(1'b0, 1'b0, 32'h10, 32'd0, 0, 1'b0, 0, rd, lat, ys);
        post("load_word_10", rd, 32'hDEADBEEF);
        post("load_latency", lat, 32'd2);
        xact(1'b0, 1'b0, 32'h1010, 32'd0, 0, 1'b0, 0, rd, lat, ys);
        post("alias_1010", rd, 32'hDEADBEEF);

        // byte store into an existing word
        xact(1'b1, 1'b0, 32'h10, 32'h11223344, 0, 1'b0, 0, rd, lat, ys);
        xact(1'b1, 1'b1, 32'h13, 32'hFFFFFF5A, 0, 1'b0, 0, rd, lat, ys);
        xact(1'b0, 1'b0, 32'h10, 32'd0, 0, 1'b0, 0, rd, lat, ys);
        post("merged_word", rd, 32'h5A223344);
        xact(1'b0, 1'b1, 32'h13, 32'd0, 0, 1'b0, 0, rd, lat, ys);
        post("lbu_13", rd, 32'h0000005A);
        xact(1'b0, 1'b1, 32'h11, 32'd0, 1, 1'b0, 0, rd, lat, ys);
        post("lbu_11", rd, 32'h00000033);

        // response held 5 cycles with a new request waiting
        xact(1'b1, 1'b0, 32'h14, 32'h01020304, 0, 1'b0, 0, rd, lat, ys);
        xact(1'b0, 1'b0, 32'h10, 32'd0, 5, 1'b1, 32'h14, rd, lat, ys);
        post("held_data", rd, 32'h5A223344);
        post("no_yumi_in_resp", ys, 32'd0);
        xact(1'b0, 1'b0, 32'h14, 32'd0, 0, 1'b0, 0, rd, lat, ys);
        post("queued_load_14", rd, 32'h01020304);

        // reset during BUSY drops the store
        xact(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 0, 1'b0, 0, rd, lat, ys);
        req.valid = 1'b1;
        req.wen = 1'b1;
        req.byte_not_word = 1'b0;
        req.write_data = 32'h55555555;
        addr = 32'h20;
        @(posedge clk); #1;
        req.valid = 1'b0;
        post("busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        post("reset_mid_valid", {31'd0, resp.valid}, 32'd0);
        post("reset_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        xact(1'b0, 1'b0, 32'h20, 32'd0, 0, 1'b0, 0, rd, lat, ys);
        post("dropped_store_20", rd, 32'hCAFEF00D);

        // misaligned word store
        xact(1'b1, 1'b0, 32'h22, 32'hA5A5A5A5, 0, 1'b0, 0, rd, lat, ys);
        xact(1'b0, 1'b0, 32'h20, 32'd0, 0, 1'b0, 0, rd, lat, ys);
`ifdef DMEM_MISALIGN_TRAP_EN
        post("misaligned_no_write", rd, 32'hCAFEF00D);
        post("err_sticky", {31'd0, err}, 32'd1);
`else
        post("aligned_down_write", rd, 32'hA5A5A5A5);
        post("err_tied_low", {31'd0, err}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
